// File: rtl/piarb_buf_wr_ctrl_pkg.sv
// piarb_buf_wr_ctrl_pkg: shared sizes, FSM encoding and helpers for the PIARB write-side buffer allocator
package piarb_buf_wr_ctrl_pkg;
  localparam int NUM_PU = 4;
  localparam int ID_NBITS = 2;
  localparam int BPTR_NBITS = 8;
  localparam int BPTR_LSB_NBITS = 2;
  localparam int DATA_NBITS = 16;
  localparam int CACHE_DEPTH = 4;
  localparam int LEN_NBITS = 16;
  localparam int CNT_NBITS = $clog2(CACHE_DEPTH) + 1;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
  function automatic logic [LEN_NBITS-1:0] len_inc(input logic [LEN_NBITS-1:0] l);
    return &l ? l : l + LEN_NBITS'(1);
  endfunction
endpackage

// File: rtl/piarb_buf_wr_ctrl_if.sv
// piarb_buf_wr_ctrl_if: PU word streams, free-pointer handshake, write stream and packet descriptors
// slave modport = allocator view, master modport = PU/free-list/consumer view
interface piarb_buf_wr_ctrl_if;
  import piarb_buf_wr_ctrl_pkg::*;
  logic                         freeb_init_done;
  logic [NUM_PU-1:0]            pu_valid;
  logic [NUM_PU-1:0]            pu_sop;
  logic [NUM_PU-1:0]            pu_eop;
  logic [NUM_PU*DATA_NBITS-1:0] pu_data;
  logic [NUM_PU-1:0]            pu_ready;
  logic                         free_buf_req;
  logic                         free_buf_valid;
  logic [BPTR_NBITS-1:0]        free_buf_ptr;
  logic                         write_data_valid;
  logic [BPTR_NBITS-1:0]        write_buf_ptr;
  logic [BPTR_LSB_NBITS-1:0]    write_buf_ptr_lsb;
  logic                         write_sop;
  logic                         write_eop;
  logic [ID_NBITS-1:0]          write_port_id;
  logic [DATA_NBITS-1:0]        write_data;
  logic                         pkt_done_valid;
  logic [ID_NBITS-1:0]          pkt_done_port_id;
  logic [BPTR_NBITS-1:0]        pkt_done_head_ptr;
  logic [LEN_NBITS-1:0]         pkt_done_len;
  modport slave (
    input  freeb_init_done, pu_valid, pu_sop, pu_eop, pu_data, free_buf_valid, free_buf_ptr,
    output pu_ready, free_buf_req, write_data_valid, write_buf_ptr, write_buf_ptr_lsb,
           write_sop, write_eop, write_port_id, write_data,
           pkt_done_valid, pkt_done_port_id, pkt_done_head_ptr, pkt_done_len
  );
  modport master (
    output freeb_init_done, pu_valid, pu_sop, pu_eop, pu_data, free_buf_valid, free_buf_ptr,
    input  pu_ready, free_buf_req, write_data_valid, write_buf_ptr, write_buf_ptr_lsb,
           write_sop, write_eop, write_port_id, write_data,
           pkt_done_valid, pkt_done_port_id, pkt_done_head_ptr, pkt_done_len
  );
endinterface

// File: rtl/piarb_buf_wr_ptr_cache.sv
// piarb_buf_wr_ptr_cache: DEPTH x W free-pointer FIFO with flush
// ports: push/din write, pop/dout show-ahead read, flush empties, count/empty/full status
module piarb_buf_wr_ptr_cache #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/piarb_buf_wr_ctrl.sv
// piarb_buf_wr_ctrl: round-robin PU word arbiter that allocates free buffers and emits packet descriptors
// ports: clk, rst (sync, active high), bus (slave modport of piarb_buf_wr_ctrl_if)
// optional: PIARB_BUF_WR_ERR_CHK_EN adds sticky err_status[2:0]
module piarb_buf_wr_ctrl
  import piarb_buf_wr_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  piarb_buf_wr_ctrl_if.slave bus
`ifdef PIARB_BUF_WR_ERR_CHK_EN
  ,
  output logic [2:0] err_status
`endif
);
  state_t state, nxt_state;
  logic run, flush;
  logic [CNT_NBITS-1:0] cache_count, inflight;
  logic cache_empty, cache_full;
  logic [BPTR_NBITS-1:0] cache_dout;
  logic req, push, dec, pop;
  logic [BPTR_LSB_NBITS-1:0] off [NUM_PU];
  logic [BPTR_NBITS-1:0] cur_ptr [NUM_PU];
  logic [BPTR_NBITS-1:0] head [NUM_PU];
  logic [LEN_NBITS-1:0] len [NUM_PU];
  logic [NUM_PU-1:0] needs_new, elig;
  logic [ID_NBITS-1:0] last_gnt, gnt;
  logic gnt_vld, g_sop, g_eop;
  logic [BPTR_NBITS-1:0] w_ptr, nxt_head;
  logic [BPTR_LSB_NBITS-1:0] w_lsb, nxt_off;
  logic [LEN_NBITS-1:0] nxt_len;
  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else state <= nxt_state;
  always_comb begin
    nxt_state = (state == ST_IDLE) ? (bus.freeb_init_done ? ST_RUN : ST_IDLE) :
                (state == ST_RUN) ? (bus.freeb_init_done ? ST_RUN : ST_FLUSH) : ST_IDLE;
  end
  assign run = state == ST_RUN;
  assign flush = state == ST_FLUSH;
  // credit rule: outstanding requests plus cached pointers never exceed the cache size
  assign req = run && (({1'b0, cache_count} + {1'b0, inflight}) < (CNT_NBITS+1)'(CACHE_DEPTH));
  assign push = run && bus.free_buf_valid && (!cache_full || pop);
  assign dec = run && bus.free_buf_valid && inflight != '0;
  assign bus.free_buf_req = req;
  piarb_buf_wr_ptr_cache #(.DEPTH(CACHE_DEPTH), .W(BPTR_NBITS)) u_cache (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(push),
    .pop(pop),
    .din(bus.free_buf_ptr),
    .dout(cache_dout),
    .count(cache_count),
    .empty(cache_empty),
    .full(cache_full)
  );
  always_comb begin
    needs_new = '0;
    elig = '0;
    for (int p = 0; p < NUM_PU; p++) begin
      needs_new[p] = off[p] == '0 || bus.pu_sop[p];
      elig[p] = run && bus.pu_valid[p] && (!needs_new[p] || !cache_empty);
    end
  end
  // descending scan so the closest eligible port after last_gnt wins
  always_comb begin
    logic [ID_NBITS-1:0] cand;
    cand = '0;
    gnt_vld = 1'b0;
    gnt = '0;
    for (int i = NUM_PU; i >= 1; i--) begin
      cand = ID_NBITS'((int'(last_gnt) + i) % NUM_PU);
      if (elig[cand]) begin
        gnt_vld = 1'b1;
        gnt = cand;
      end
    end
  end
  assign bus.pu_ready = gnt_vld ? (NUM_PU'(1) << gnt) : '0;
  always_comb begin
    g_sop = bus.pu_sop[gnt];
    g_eop = bus.pu_eop[gnt];
    pop = gnt_vld && needs_new[gnt];
    w_ptr = pop ? cache_dout : cur_ptr[gnt];
    w_lsb = g_sop ? '0 : off[gnt];
    nxt_head = g_sop ? w_ptr : head[gnt];
    nxt_len = g_sop ? LEN_NBITS'(1) : len_inc(len[gnt]);
    nxt_off = g_eop ? '0 : w_lsb + BPTR_LSB_NBITS'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      last_gnt <= '0;
      off <= '{default: '0};
      cur_ptr <= '{default: '0};
      head <= '{default: '0};
      len <= '{default: '0};
      bus.write_data_valid <= 1'b0;
      bus.write_buf_ptr <= '0;
      bus.write_buf_ptr_lsb <= '0;
      bus.write_sop <= 1'b0;
      bus.write_eop <= 1'b0;
      bus.write_port_id <= '0;
      bus.write_data <= '0;
      bus.pkt_done_valid <= 1'b0;
      bus.pkt_done_port_id <= '0;
      bus.pkt_done_head_ptr <= '0;
      bus.pkt_done_len <= '0;
    end else begin
      inflight <= flush ? '0 : inflight + CNT_NBITS'(req) - CNT_NBITS'(dec);
      if (flush) begin
        off <= '{default: '0};
        len <= '{default: '0};
      end else if (gnt_vld) begin
        last_gnt <= gnt;
        off[gnt] <= nxt_off;
        cur_ptr[gnt] <= w_ptr;
        head[gnt] <= nxt_head;
        len[gnt] <= nxt_len;
      end
      bus.write_data_valid <= gnt_vld;
      bus.write_buf_ptr <= w_ptr;
      bus.write_buf_ptr_lsb <= w_lsb;
      bus.write_sop <= g_sop;
      bus.write_eop <= g_eop;
      bus.write_port_id <= gnt;
      bus.write_data <= bus.pu_data[gnt*DATA_NBITS +: DATA_NBITS];
      bus.pkt_done_valid <= gnt_vld && g_eop;
      bus.pkt_done_port_id <= gnt;
      bus.pkt_done_head_ptr <= nxt_head;
      bus.pkt_done_len <= nxt_len;
    end
  end
`ifdef PIARB_BUF_WR_ERR_CHK_EN
  logic [NUM_PU-1:0] active;
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
      err_status <= '0;
    end else begin
      if (flush) active <= '0;
      else if (gnt_vld) active[gnt] <= !g_eop;
      err_status <= err_status | {bus.free_buf_valid && run && inflight == '0,
                                  gnt_vld && !g_sop && !active[gnt],
                                  gnt_vld && g_sop && active[gnt]};
    end
  end
`endif
endmodule
